mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer that shares one 4:1 decoder-based mux among four requesters.

---
 rtl/mux4_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares a single 4:1 mux among four requesters.
// Each grant is bounded to MAX_HOLD cycles while others wait; the mux output is registered.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       o,
  output logic       o_valid,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hold_q, hold_d;
  logic       o_q, o_d;
  logic       o_valid_q, o_valid_d;
  logic [3:0] others;

  // First set bit of r, searching circularly upward from start.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign busy    = (state_q == GRANT);
  assign gnt     = busy ? (4'b0001 << sel_q) : 4'b0000;
  assign sel     = sel_q;
  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign others  = req & ~(4'b0001 << sel_q);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    o_d       = o_q;
    o_valid_d = 1'b0;

    if (gnt != 4'b0000) begin
      o_d       = d[sel_q];
      o_valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_d   = pick(req, ptr_q);
          hold_d  = 4'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          ptr_d = sel_q + 2'd1;
          if (others != 4'b0000) begin
            sel_d  = pick(others, sel_q + 2'd1);
            hold_d = 4'd1;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q >= MAX_HOLD_C && others != 4'b0000) begin
          ptr_d  = sel_q + 2'd1;
          sel_d  = pick(others, sel_q + 2'd1);
          hold_d = 4'd1;
        end else begin
          hold_d = (hold_q >= MAX_HOLD_C) ? MAX_HOLD_C : hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd0;
      hold_q    <= 4'd0;
      o_q       <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: a per-cycle reference model checked on every negedge,
// plus directed scenarios with hand-computed literal expectations.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       o;
  logic       o_valid;
  logic       busy;

  int errors = 0;
  int checks = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt), .sel(sel), .o(o), .o_valid(o_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the mux, how long they have owned it, and who is next in line.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_run   = 0;
  int   m_sel   = 0;
  logic m_o     = 1'b0;
  logic m_ov    = 1'b0;
  bit   model_on = 1'b0;

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [3:0] rest;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_run = 0; m_sel = 0; m_o = 1'b0; m_ov = 1'b0;
    end else begin
      if (m_owner >= 0) begin
        m_o  = d[m_owner];
        m_ov = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
      if (m_owner < 0) begin
        if (req != 4'b0) begin
          m_owner = first_from(req, m_ptr);
          m_run   = 1;
        end
      end else begin
        rest = req;
        rest[m_owner] = 1'b0;
        if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % 4;
          if (rest != 4'b0) begin
            m_owner = first_from(rest, m_ptr);
            m_run   = 1;
          end else begin
            m_owner = -1;
          end
        end else if (m_run >= MAX_HOLD && rest != 4'b0) begin
          m_ptr   = (m_owner + 1) % 4;
          m_owner = first_from(rest, m_ptr);
          m_run   = 1;
        end else if (m_run < MAX_HOLD) begin
          m_run++;
        end
      end
      if (m_owner >= 0) m_sel = m_owner;
    end
  end

  // Compare process: every negedge once the model has seen its first reset.
  always @(negedge clk) begin
    if (model_on) begin
      check("gnt",     32'(gnt),     (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
      check("sel",     32'(sel),     32'(m_sel));
      check("busy",    32'(busy),    32'(m_owner >= 0));
      check("o_valid", 32'(o_valid), 32'(m_ov));
      check("o",       32'(o),       32'(m_o));
    end
  end

  // One clock: apply inputs now, then return 1 time unit after the edge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] dv);
    req = r;
    d   = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle(4'b0000, 4'b0000);
    cycle(4'b0000, 4'b0000);
    rst_n = 1'b1;
  endtask

  typedef struct { logic [3:0] r; logic [3:0] dv; } vec_t;

  initial begin
    vec_t vecs[$];
    int   exp_owner;

    rst_n = 1'b0;
    req   = 4'b0;
    d     = 4'b0;
    @(posedge clk);
    #1;
    model_on = 1'b1;
    do_reset();

    // Reset state and idle
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_ov",  32'(o_valid), 32'd0);
    for (int i = 0; i < 10; i++) cycle(4'b0000, 4'(i));
    check("idle_gnt",  32'(gnt), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Single requester 2, latency 1, data lags by 1
    cycle(4'b0100, 4'b0100);
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_sel", 32'(sel), 32'd2);
    cycle(4'b0100, 4'b0100);
    check("t2_o",  32'(o), 32'd1);
    check("t2_ov", 32'(o_valid), 32'd1);
    cycle(4'b0000, 4'b0000);
    cycle(4'b0000, 4'b0000);
    check("t2_idle_sel_hold", 32'(sel), 32'd2);

    // All request: rotate 0,1,2,3,0 with MAX_HOLD cycles each
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      cycle(4'b1111, 4'(k));
      exp_owner = ((k - 1) / MAX_HOLD) % 4;
      check("t3_rotate", 32'(gnt), 32'(1 << exp_owner));
    end

    // Lone requester never preempted
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cycle(4'b0001, 4'($urandom_range(0, 15)));
      check("t4_hold", 32'(gnt), 32'h1);
    end

    // Owner 1 releases with 3 and 0 waiting -> 3, then 3 releases -> 0
    do_reset();
    cycle(4'b0010, 4'b0000);
    check("t5_own1", 32'(gnt), 32'h2);
    cycle(4'b1011, 4'b0000);
    check("t5_keep1", 32'(gnt), 32'h2);
    cycle(4'b1001, 4'b0000);
    check("t5_to3", 32'(gnt), 32'h8);
    cycle(4'b0001, 4'b0000);
    check("t5_to0", 32'(gnt), 32'h1);

    // Reset mid-grant
    do_reset();
    cycle(4'b0010, 4'b0010);
    check("t6_gnt", 32'(gnt), 32'h2);
    rst_n = 1'b0;
    cycle(4'b0010, 4'b0010);
    check("t6_rst_gnt", 32'(gnt), 32'd0);
    check("t6_rst_sel", 32'(sel), 32'd0);
    check("t6_rst_ov",  32'(o_valid), 32'd0);
    rst_n = 1'b1;
    cycle(4'b0011, 4'b0011);
    check("t6_after", 32'(gnt), 32'h1);

    // Mixed directed vectors, checked by the model only
    vecs = '{
      '{4'b1010, 4'b1010}, '{4'b1010, 4'b0010}, '{4'b1110, 4'b1111},
      '{4'b1110, 4'b0100}, '{4'b1100, 4'b1000}, '{4'b1100, 4'b0100},
      '{4'b0101, 4'b0001}, '{4'b0111, 4'b0110}, '{4'b0111, 4'b0010},
      '{4'b0111, 4'b0101}, '{4'b0111, 4'b0011}, '{4'b0111, 4'b0100},
      '{4'b0011, 4'b0001}, '{4'b1000, 4'b1000}, '{4'b0000, 4'b0000},
      '{4'b1001, 4'b1001}, '{4'b0110, 4'b0110}, '{4'b0000, 4'b1111}
    };
    foreach (vecs[i]) begin
      for (int j = 0; j < 3; j++) cycle(vecs[i].r, vecs[i].dv ^ 4'(j));
    end
    cycle(4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
